// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the M-stage data-memory port.
// Holds the responder FSM state encoding and the address legality check.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int unsigned WORD_BYTES = 4;

    // Legal means word aligned and inside the DEPTH-word array.
    function automatic logic addr_legal(input logic [31:0] addr, input int unsigned depth);
        logic [31:0] limit;
        limit = 32'(depth * WORD_BYTES);
        return (addr[1:0] == 2'b00) && (addr < limit);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// M-stage data-memory port: request/ready handshake, write data, read data, error and stall.
// The master (M stage) holds req/we/addr/wdata stable until it sees ready.
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        stall;

    modport master (output req, we, addr, wdata, input rdata, ready, err, stall);
    modport slave  (input req, we, addr, wdata, output rdata, ready, err, stall);
endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage, synchronous write, asynchronous read.
// Latency: write lands at the clock edge, read is combinational from idx.
// Backpressure: none; no reset, contents survive core reset.
module dmem_array #(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wd,
    output logic [31:0]      rd
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wd;
        end
    end

    assign rd = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage with LATENCY programmable wait states.
// Latency: ready pulses LATENCY+1 cycles after req is accepted; transaction is LATENCY+2 cycles.
// Backpressure: stall = req & ~ready holds the pipeline; new requests accepted only in IDLE.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    dmem_responder_if.slave    bus
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    dmem_state_t      state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             cap_we;
    logic             cap_legal;
    logic [IDX_W-1:0] cap_idx;
    logic [31:0]      cap_wdata;
    logic [31:0]      arr_rd;
    logic             arr_we;
    logic             resp;
    logic             accept;

    assign accept = (state == IDLE) && bus.req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_legal <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Request fields are snapshotted once; the master may drop them afterwards.
            if (accept) begin
                cap_we    <= bus.we;
                cap_legal <= addr_legal(bus.addr, DEPTH);
                cap_idx   <= bus.addr[IDX_W+1:2];
                cap_wdata <= bus.wdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.req) begin
                    cnt_nxt   = CNT_INIT;
                    state_nxt = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign resp   = (state == RESP);
    // Commit happens on the edge that ends RESP, so a reset before then loses the write.
    assign arr_we = resp && cap_we && cap_legal;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk (clk),
        .we  (arr_we),
        .idx (cap_idx),
        .wd  (cap_wdata),
        .rd  (arr_rd)
    );

    assign bus.ready = resp;
    assign bus.err   = resp && !cap_legal;
    assign bus.rdata = (resp && !cap_we && cap_legal) ? arr_rd : 32'd0;
    assign bus.stall = bus.req && !resp;

endmodule
